// File: rtl/vector_slide_pipe.sv
// vector_slide_pipe: two-stage valid/ready wrapper around the
// lane slide network (slide up / slide down with fill vector).
module vector_slide_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int VECTOR_LANES = 16,
   parameter int WIDTH        = $clog2(VECTOR_LANES)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_dir,
   input  logic [WIDTH:0]                     in_offset,
   input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vec_a,
   input  logic [VECTOR_LANES*DATA_WIDTH-1:0] in_vec_b,
   input  logic [4:0]                         in_vd,
   input  logic                               flush,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [VECTOR_LANES*DATA_WIDTH-1:0] out_vec,
   output logic [4:0]                         out_vd
);

   localparam int VW = VECTOR_LANES * DATA_WIDTH;

   function automatic logic [VW-1:0] lane_rev(
      input logic [VW-1:0] v
   );
      logic [VW-1:0] r;
      r = '0;
      for (int i = 0; i < VECTOR_LANES; i++) begin
         r[i*DATA_WIDTH +: DATA_WIDTH] =
            v[(VECTOR_LANES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
      return r;
   endfunction

   logic [VW-1:0]    a1_q, a1_d;
   logic [VW-1:0]    b1_q, b1_d;
   logic [WIDTH-1:0] sh1_q, sh1_d;
   logic             allb1_q, allb1_d;
   logic             dir1_q, dir1_d;
   logic [4:0]       vd1_q, vd1_d;
   logic             v1_q, v1_d;
   logic [VW-1:0]    out_vec_q, out_vec_d;
   logic [4:0]       out_vd_q, out_vd_d;
   logic             out_valid_q, out_valid_d;

   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   logic [VW-1:0]    slide_r;

   assign s2_adv   = ~out_valid_q | out_ready;
   assign s1_adv   = ~v1_q | s2_adv;
   assign in_ready = s1_adv & ~flush & rst_n;
   assign in_fire  = in_valid & in_ready;

   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_vd    = out_vd_q;

   // S1: capture request; slide-down is done as slide-up on reversed lanes
   always_comb begin
      a1_d    = a1_q;
      b1_d    = b1_q;
      sh1_d   = sh1_q;
      allb1_d = allb1_q;
      dir1_d  = dir1_q;
      vd1_d   = vd1_q;
      v1_d    = v1_q;
      if (in_fire) begin
         a1_d    = in_dir ? lane_rev(in_vec_a) : in_vec_a;
         b1_d    = in_dir ? lane_rev(in_vec_b) : in_vec_b;
         sh1_d   = in_offset[WIDTH-1:0];
         allb1_d = in_offset[WIDTH];
         dir1_d  = in_dir;
         vd1_d   = in_vd;
      end
      if (flush) begin
         v1_d = 1'b0;
      end else if (s1_adv) begin
         v1_d = in_fire;
      end
   end

   // Slide-up network: log shifter, a lane mask tracks which lanes keep a
   always_comb begin
      logic [VW-1:0]           dat;
      logic [VECTOR_LANES-1:0] msk;
      dat     = a1_q;
      msk     = '1;
      slide_r = '0;
      for (int s = 0; s < WIDTH; s++) begin
         if (sh1_q[WIDTH-1-s]) begin
            dat = dat << (DATA_WIDTH * (1 << (WIDTH-1-s)));
            msk = msk << (1 << (WIDTH-1-s));
         end
      end
      for (int i = 0; i < VECTOR_LANES; i++) begin
         slide_r[i*DATA_WIDTH +: DATA_WIDTH] = msk[i]
            ? dat[i*DATA_WIDTH +: DATA_WIDTH]
            : b1_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // S2: undo the reversal and register the result with its tag
   always_comb begin
      out_vec_d   = out_vec_q;
      out_vd_d    = out_vd_q;
      out_valid_d = out_valid_q;
      if (s2_adv) begin
         if (allb1_q) begin
            out_vec_d = dir1_q ? lane_rev(b1_q) : b1_q;
         end else if (dir1_q) begin
            out_vec_d = lane_rev(slide_r);
         end else begin
            out_vec_d = slide_r;
         end
         out_vd_d    = vd1_q;
         out_valid_d = v1_q;
      end
      if (flush) begin
         out_valid_d = 1'b0;
      end
   end

   // Pipeline state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q        <= '0;
         b1_q        <= '0;
         sh1_q       <= '0;
         allb1_q     <= 1'b0;
         dir1_q      <= 1'b0;
         vd1_q       <= '0;
         v1_q        <= 1'b0;
         out_vec_q   <= '0;
         out_vd_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         a1_q        <= a1_d;
         b1_q        <= b1_d;
         sh1_q       <= sh1_d;
         allb1_q     <= allb1_d;
         dir1_q      <= dir1_d;
         vd1_q       <= vd1_d;
         v1_q        <= v1_d;
         out_vec_q   <= out_vec_d;
         out_vd_q    <= out_vd_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
